// File: rtl/sound_ctrl_latch.sv
// sound_ctrl_latch
//
// Takes 6502 writes to the sound control latch and turns them into the level
// and trigger inputs of the analog sound mixer. Battlezone uses the latch at
// BZ_ADDR. Red Baron uses the crash/shot latch at RB_ADDR. The two trigger
// bits (shell, explosion) are stretched so that they stay high for at least
// STRETCH_TICKS ticks of the 12 kHz noise clock. Without this, the noise
// sources could miss a short CPU pulse.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   clk_3MHz_en    in   CPU bus qualifier; bus inputs are sampled only when 1
//   clk_12KHz_en   in   noise-source tick, drives the strobe stretchers
//   mod_redbaron   in   0 = Battlezone decode, 1 = Red Baron decode
//   cpu_addr[15:0] in   CPU address
//   cpu_dout[7:0]  in   CPU write data
//   cpu_we         in   CPU write strobe (level)
//   sound_enable   out  master analog enable
//   motor_en       out  engine on (Battlezone)
//   engine_rev_en  out  engine high-rev select (Battlezone)
//   shell_ls       out  shell trigger, stretched
//   shell_en       out  shell / shot noise enable
//   explo_ls       out  explosion trigger, stretched (Battlezone)
//   explo_en       out  explosion enable (Battlezone)
//   crsh[3:0]      out  crash amplitude (Red Baron)
//   latch_q[7:0]   out  last byte accepted into the active latch
module sound_ctrl_latch #(
  parameter logic [15:0] BZ_ADDR       = 16'h1840,
  parameter logic [15:0] RB_ADDR       = 16'h1808,
  parameter int unsigned STRETCH_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_3MHz_en,
  input  logic        clk_12KHz_en,
  input  logic        mod_redbaron,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        sound_enable,
  output logic        motor_en,
  output logic        engine_rev_en,
  output logic        shell_ls,
  output logic        shell_en,
  output logic        explo_ls,
  output logic        explo_en,
  output logic [3:0]  crsh,
  output logic [7:0]  latch_q
);

  localparam logic [3:0] RELOAD = 4'(STRETCH_TICKS - 1);

  // Stretcher index: 0 = explosion, 1 = shell
  localparam int EXPLO = 0;
  localparam int SHELL = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLD} st_e;

  logic       mode_q;
  logic       we_prev_q;
  logic [7:0] byte_q;
  logic       sound_enable_q;
  logic       motor_en_q;
  logic       engine_rev_en_q;
  logic       shell_en_q;
  logic       explo_en_q;
  logic [3:0] crsh_q;

  logic [1:0] req_q;
  logic [1:0] req_d;
  logic [1:0] rise;
  st_e        st_q  [2];
  logic [3:0] cnt_q [2];
  logic [1:0] exp_q;   // minimum stretch elapsed while req was still high
  logic [1:0] out_q;

  logic addr_hit;
  logic mode_chg;
  logic wr_acc;

  assign addr_hit = (cpu_addr == (mod_redbaron ? RB_ADDR : BZ_ADDR));
  assign mode_chg = (mod_redbaron != mode_q);
  // The edge detector only advances on bus-qualified cycles. A write that is
  // held over several enables is therefore seen once.
  assign wr_acc   = clk_3MHz_en & cpu_we & ~we_prev_q & addr_hit & ~mode_chg;

  // Trigger request levels after this cycle's write. Red Baron has no
  // stretched triggers.
  always_comb begin
    req_d = req_q;
    if (wr_acc) begin
      req_d[EXPLO] = ~mod_redbaron & cpu_dout[0];
      req_d[SHELL] = ~mod_redbaron & cpu_dout[2];
    end
    rise = req_d & ~req_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q          <= 1'b0;
      // Treated as already high, so a cpu_we that is held across reset
      // release does not produce a phantom write.
      we_prev_q       <= 1'b1;
      byte_q          <= 8'h00;
      sound_enable_q  <= 1'b0;
      motor_en_q      <= 1'b0;
      engine_rev_en_q <= 1'b0;
      shell_en_q      <= 1'b0;
      explo_en_q      <= 1'b0;
      crsh_q          <= 4'h0;
      req_q           <= 2'b00;
      exp_q           <= 2'b00;
      out_q           <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= 4'h0;
      end
    end else begin
      if (clk_3MHz_en) begin
        we_prev_q <= cpu_we;
      end
      mode_q <= mod_redbaron;

      if (mode_chg) begin
        // A game-mode switch silences everything. A write in the same cycle
        // is dropped.
        byte_q          <= 8'h00;
        sound_enable_q  <= 1'b0;
        motor_en_q      <= 1'b0;
        engine_rev_en_q <= 1'b0;
        shell_en_q      <= 1'b0;
        explo_en_q      <= 1'b0;
        crsh_q          <= 4'h0;
        req_q           <= 2'b00;
        exp_q           <= 2'b00;
        out_q           <= 2'b00;
        for (int i = 0; i < 2; i++) begin
          st_q[i]  <= ST_IDLE;
          cnt_q[i] <= 4'h0;
        end
      end else begin
        if (wr_acc) begin
          byte_q         <= cpu_dout;
          req_q          <= req_d;
          sound_enable_q <= cpu_dout[5];
          if (mod_redbaron) begin
            crsh_q          <= cpu_dout[3:0];
            shell_en_q      <= cpu_dout[4];
            motor_en_q      <= 1'b0;
            engine_rev_en_q <= 1'b0;
            explo_en_q      <= 1'b0;
          end else begin
            crsh_q          <= 4'h0;
            explo_en_q      <= cpu_dout[1];
            shell_en_q      <= cpu_dout[3];
            engine_rev_en_q <= cpu_dout[4];
            motor_en_q      <= cpu_dout[7];
          end
        end

        // Strobe stretchers. A fresh 0->1 request takes priority over a
        // coincident 12 kHz tick.
        for (int i = 0; i < 2; i++) begin
          if (rise[i]) begin
            out_q[i] <= 1'b1;
            exp_q[i] <= 1'b0;
            if (st_q[i] == ST_IDLE) begin
              st_q[i] <= ST_ARMED;
            end else begin
              st_q[i]  <= ST_HOLD;
              cnt_q[i] <= RELOAD;
            end
          end else begin
            case (st_q[i])
              ST_ARMED: begin
                if (clk_12KHz_en) begin
                  st_q[i]  <= ST_HOLD;
                  cnt_q[i] <= RELOAD;
                end
              end
              ST_HOLD: begin
                if (exp_q[i]) begin
                  // Minimum width already met: follow the CPU level down.
                  if (!req_d[i]) begin
                    st_q[i]  <= ST_IDLE;
                    out_q[i] <= 1'b0;
                    exp_q[i] <= 1'b0;
                  end
                end else if (clk_12KHz_en) begin
                  if (cnt_q[i] != 4'h0) begin
                    cnt_q[i] <= cnt_q[i] - 4'h1;
                  end else if (!req_d[i]) begin
                    st_q[i]  <= ST_IDLE;
                    out_q[i] <= 1'b0;
                  end else begin
                    exp_q[i] <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign sound_enable  = sound_enable_q;
  assign motor_en      = motor_en_q;
  assign engine_rev_en = engine_rev_en_q;
  assign shell_ls      = out_q[SHELL];
  assign shell_en      = shell_en_q;
  assign explo_ls      = out_q[EXPLO];
  assign explo_en      = explo_en_q;
  assign crsh          = crsh_q;
  assign latch_q       = byte_q;

endmodule

// File: tb/tb_sound_ctrl_latch.sv
module tb_sound_ctrl_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_3MHz_en;
  logic        clk_12KHz_en;
  logic        mod_redbaron;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        sound_enable;
  logic        motor_en;
  logic        engine_rev_en;
  logic        shell_ls;
  logic        shell_en;
  logic        explo_ls;
  logic        explo_en;
  logic [3:0]  crsh;
  logic [7:0]  latch_q;

  sound_ctrl_latch #(
    .BZ_ADDR       (16'h1840),
    .RB_ADDR       (16'h1808),
    .STRETCH_TICKS (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_3MHz_en   (clk_3MHz_en),
    .clk_12KHz_en  (clk_12KHz_en),
    .mod_redbaron  (mod_redbaron),
    .cpu_addr      (cpu_addr),
    .cpu_dout      (cpu_dout),
    .cpu_we        (cpu_we),
    .sound_enable  (sound_enable),
    .motor_en      (motor_en),
    .engine_rev_en (engine_rev_en),
    .shell_ls      (shell_ls),
    .shell_en      (shell_en),
    .explo_ls      (explo_ls),
    .explo_en      (explo_en),
    .crsh          (crsh),
    .latch_q       (latch_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed vector: {se, motor, rev, shell_ls, shell_en, explo_ls, explo_en, crsh, latch}
  logic [18:0] obs;
  assign obs = {sound_enable, motor_en, engine_rev_en, shell_ls, shell_en,
                explo_ls, explo_en, crsh, latch_q};

  function automatic logic [18:0] mk(input bit se, input bit me, input bit er,
                                     input bit sls, input bit sen, input bit els,
                                     input bit een, input logic [3:0] c,
                                     input logic [7:0] l);
    return {se, me, er, sls, sen, els, een, c, l};
  endfunction

  // Scoreboard: expected output snapshot tagged with the cycle it applies to
  int          q_cyc  [$];
  logic [18:0] q_val  [$];
  string       q_name [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic expect_at(input int dc, input logic [18:0] v, input string nm);
    q_cyc.push_back(cyc + dc);
    q_val.push_back(v);
    q_name.push_back(nm);
  endtask

  // Monitor: compares at the falling edge against whatever is due this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        n_chk++;
        if (q_cyc[0] < cyc) begin
          n_fail++;
          $display("FAIL %s: due on cycle %0d, not examined until %0d", q_name[0], q_cyc[0], cyc);
        end else if (obs !== q_val[0]) begin
          n_fail++;
          $display("FAIL %s: got %05h, expected %05h (se,mo,rev,sls,sen,els,een,crsh,latch)",
                   q_name[0], obs, q_val[0]);
        end
        void'(q_cyc.pop_front());
        void'(q_val.pop_front());
        void'(q_name.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus write: qualified cycle with we high, then a qualified cycle with we low
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr    = a;
    cpu_dout    = d;
    cpu_we      = 1'b1;
    clk_3MHz_en = 1'b1;
    step();
    cpu_we = 1'b0;
    step();
    clk_3MHz_en = 1'b0;
  endtask

  task automatic tick();
    clk_12KHz_en = 1'b1;
    step();
    clk_12KHz_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    mod_redbaron = 1'b0;
    cpu_addr     = 16'h1840;
    cpu_dout     = 8'hFF;
    cpu_we       = 1'b1;
    clk_3MHz_en  = 1'b1;
    clk_12KHz_en = 1'b0;
    step();
    step();
    expect_at(0, 19'h0, "reset_state");
    step();
    // Release reset with a matching write held on the bus: must not be taken
    rst_n = 1'b1;
    step();
    step();
    step();
    expect_at(0, 19'h0, "no_write_on_reset_release");
    cpu_we = 1'b0;
    step();
    clk_3MHz_en = 1'b0;

    // Battlezone decode and explosion stretch
    expect_at(1, mk(1,1,0,0,0,1,1,4'h0,8'hA3), "bz_write_a3");
    wr(16'h1840, 8'hA3);
    expect_at(1, mk(1,1,0,0,0,1,1,4'h0,8'hA2), "bz_ls_held_after_clear");
    wr(16'h1840, 8'hA2);
    tick();
    tick();
    expect_at(0, mk(1,1,0,0,0,1,1,4'h0,8'hA2), "explo_high_before_expire");
    expect_at(1, mk(1,1,0,0,0,0,1,4'h0,8'hA2), "explo_stretch_end");
    tick();

    // Shell strobe: 0x04 then 0x00, stretch of two ticks after arming
    expect_at(1, mk(0,0,0,1,0,0,0,4'h0,8'h04), "shell_write_04");
    wr(16'h1840, 8'h04);
    expect_at(1, mk(0,0,0,1,0,0,0,4'h0,8'h00), "shell_held_after_00");
    wr(16'h1840, 8'h00);
    tick();
    expect_at(0, mk(0,0,0,1,0,0,0,4'h0,8'h00), "shell_tick1_high");
    tick();
    expect_at(0, mk(0,0,0,1,0,0,0,4'h0,8'h00), "shell_tick2_high");
    expect_at(1, 19'h0, "shell_tick3_low");
    tick();

    // cpu_we held for 10 qualified cycles: exactly one write, no retrigger
    cpu_addr    = 16'h1840;
    cpu_dout    = 8'h01;
    cpu_we      = 1'b1;
    clk_3MHz_en = 1'b1;
    expect_at(1, mk(0,0,0,0,0,1,0,4'h0,8'h01), "held_we_accept");
    step();
    cpu_dout = 8'h03;
    for (int i = 1; i < 10; i++) begin
      clk_12KHz_en = (i == 3 || i == 6);
      step();
    end
    clk_12KHz_en = 1'b0;
    expect_at(0, mk(0,0,0,0,0,1,0,4'h0,8'h01), "held_we_single_write");
    cpu_we = 1'b0;
    step();
    clk_3MHz_en = 1'b0;
    expect_at(1, mk(0,0,0,0,0,1,0,4'h0,8'h00), "held_we_clear");
    wr(16'h1840, 8'h00);
    expect_at(1, 19'h0, "held_we_expire_no_retrigger");
    tick();

    // Retrigger coincident with a tick while HOLD counter is 0
    wr(16'h1840, 8'h01);
    wr(16'h1840, 8'h00);
    tick();
    tick();
    cpu_addr     = 16'h1840;
    cpu_dout     = 8'h01;
    cpu_we       = 1'b1;
    clk_3MHz_en  = 1'b1;
    clk_12KHz_en = 1'b1;
    expect_at(1, mk(0,0,0,0,0,1,0,4'h0,8'h01), "retrig_write");
    step();
    cpu_we       = 1'b0;
    clk_12KHz_en = 1'b0;
    step();
    clk_3MHz_en = 1'b0;
    tick();
    expect_at(0, mk(0,0,0,0,0,1,0,4'h0,8'h01), "retrig_tick1_high");
    expect_at(1, mk(0,0,0,0,0,1,0,4'h0,8'h00), "retrig_clear_still_high");
    wr(16'h1840, 8'h00);
    expect_at(1, 19'h0, "retrig_tick2_low");
    tick();

    // Red Baron decode
    mod_redbaron = 1'b1;
    step();
    step();
    expect_at(1, mk(1,0,0,0,1,0,0,4'hA,8'h3A), "rb_write_3a");
    wr(16'h1808, 8'h3A);
    expect_at(1, mk(1,0,0,0,1,0,0,4'hA,8'h3A), "rb_bz_addr_ignored");
    wr(16'h1840, 8'h55);
    expect_at(1, mk(1,0,0,0,1,0,0,4'hF,8'hFF), "rb_forced_zero_ff");
    wr(16'h1808, 8'hFF);

    // Mode change with outputs active, write in the same cycle is dropped
    mod_redbaron = 1'b0;
    cpu_addr     = 16'h1840;
    cpu_dout     = 8'hA3;
    cpu_we       = 1'b1;
    clk_3MHz_en  = 1'b1;
    expect_at(1, 19'h0, "mode_change_clear");
    step();
    cpu_we = 1'b0;
    step();
    clk_3MHz_en = 1'b0;
    expect_at(0, 19'h0, "mode_change_write_dropped");

    // Asynchronous reset in the middle of a shell HOLD
    expect_at(1, mk(1,0,0,1,1,0,0,4'h0,8'h2C), "bz_write_2c");
    wr(16'h1840, 8'h2C);
    tick();
    rst_n = 1'b0;
    expect_at(0, 19'h0, "async_reset_mid_hold");
    step();
    step();
    rst_n       = 1'b1;
    clk_3MHz_en = 1'b1;
    step();
    clk_3MHz_en = 1'b0;

    // Stretcher restarts from IDLE: full ARMED + two-tick HOLD sequence
    expect_at(1, mk(0,0,0,1,0,0,0,4'h0,8'h04), "post_reset_write_04");
    wr(16'h1840, 8'h04);
    wr(16'h1840, 8'h00);
    tick();
    tick();
    expect_at(0, mk(0,0,0,1,0,0,0,4'h0,8'h00), "post_reset_stretch_high");
    expect_at(1, 19'h0, "post_reset_stretch_low");
    tick();

    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) step();
    if (q_cyc.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", q_cyc.size());
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_ctrl_latch.md
Name: sound_ctrl_latch

Overview:
- CPU-side writer for the analog sound mixer's control inputs.
- Decodes 6502 writes to the sound control latch (Battlezone) or crash/shot latch (Red Baron) into the mixer's level and strobe signals.
- Stretches the trigger strobes so the 12 kHz-sampled noise sources never miss them.
- Sits between the CPU address/data bus and the analog mixer inside the game core.

Parameters:
- BZ_ADDR, 16'h1840, Battlezone sound latch address (full 16-bit decode).
- RB_ADDR, 16'h1808, Red Baron sound latch address (full 16-bit decode).
- STRETCH_TICKS, 2, minimum number of clk_12KHz_en ticks a stretched strobe stays high (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_3MHz_en  in  1  CPU bus qualifier; bus inputs are sampled only on cycles where this is 1.
- clk_12KHz_en  in  1  noise-source tick, used for stretching.
- mod_redbaron  in  1  0 = Battlezone decode, 1 = Red Baron decode.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe, level.
- sound_enable  out  1  master analog enable.
- motor_en  out  1  engine on.
- engine_rev_en  out  1  engine high-rev select.
- shell_ls  out  1  shell trigger, stretched.
- shell_en  out  1  shell enable.
- explo_ls  out  1  explosion trigger, stretched.
- explo_en  out  1  explosion enable.
- crsh  out  4  Red Baron crash amplitude.
- latch_q  out  8  readback of the last byte written to the active latch.

Behaviour:
- Write detection:
  - A write is accepted on a cycle where clk_3MHz_en=1, cpu_we=1, and cpu_addr equals the address for the current mode.
  - The write uses the rising edge of the qualified cpu_we: cpu_we held high for several 3 MHz enables counts as one write.
  - Outputs update on the clock after the accepted cycle (latency 1 clk).
- Battlezone mode (mod_redbaron=0), written byte d:
  - explo_ls_req=d0, explo_en=d1, shell_ls_req=d2, shell_en=d3, engine_rev_en=d4, sound_enable=d5, motor_en=d7. d6 is stored only.
- Red Baron mode (mod_redbaron=1), written byte d:
  - crsh=d[3:0], shell_en=d4, sound_enable=d5. shell_en gates the shot noise.
  - motor_en, engine_rev_en, explo_en and explo_ls are forced to 0.
- latch_q holds the last accepted byte.
- Strobe stretcher, one independent instance each for shell_ls and explo_ls:
  - States: IDLE, ARMED, HOLD.
  - IDLE -> ARMED when a write sets the req bit 0->1; the output goes high the same cycle as the register update.
  - ARMED -> HOLD on the first clk_12KHz_en; a tick counter loads STRETCH_TICKS-1.
  - HOLD decrements the counter on each clk_12KHz_en. When the counter is 0 and req=0, go to IDLE and drive the output low.
  - If req is still 1 when the counter expires, stay in HOLD and keep the output high until req=0.
  - The output is therefore high for at least STRETCH_TICKS 12 kHz ticks and never shorter than the CPU level.
  - A new 0->1 req while in ARMED or HOLD reloads the counter to STRETCH_TICKS-1 (retrigger) and stays in or enters HOLD.
  - If clk_12KHz_en and a retrigger write occur in the same cycle, the retrigger wins.
- Mode change:
  - Any change of mod_redbaron, detected by a registered compare, clears all outputs, latch_q and both stretchers to IDLE on the next clk, giving silence.
  - A write accepted in the same cycle as the mode change is discarded.
- Reset: every output is 0 and both stretchers are IDLE, asynchronously. On reset release, no write is assumed pending even if cpu_we is high: the edge detector resets to "previous=1".
- Writes to any other address are ignored. Reads have no side effects.

Test Plan:
- Reset, then BZ write 8'hA3 to 16'h1840 -> next clk: sound_enable=1, motor_en=1, explo_en=1, explo_ls=1, shell_ls=0, engine_rev_en=0, latch_q=8'hA3.
- BZ write 8'h04, then 8'h00 one 3 MHz enable later, STRETCH_TICKS=2 -> shell_ls high from write+1 clk through the second clk_12KHz_en after the first, then low.
- cpu_we held high for 10 qualified cycles with 8'h01 -> exactly one accepted write; explo_ls stretch starts once and does not retrigger.
- RB mode, write 8'h3A to 16'h1808 -> crsh=4'hA, shell_en=1, sound_enable=1, motor_en=0; the same write to 16'h1840 -> no change.
- Retrigger: explo_ls in HOLD with counter 0, write 0->1 on the same cycle as clk_12KHz_en -> counter reloads to 1 and explo_ls stays high two more ticks.
- Toggle mod_redbaron with outputs active, and separately assert rst_n=0 mid-HOLD -> all outputs 0 next clk (mode change) or immediately (reset); stretchers IDLE.
